// File: rtl/mac_sequencer_pkg.sv
// Shared types and ALU control codes for the EX-stage multiply/MAC sequencer.
package mac_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mac_state_e;

    localparam logic [3:0] MUL_OP = 4'd8;
    localparam logic [3:0] MAC_OP = 4'd9;

    // ALU control decode uses this to qualify the sequencer start.
    function automatic logic is_mul_issue(input logic [3:0] alu_op);
        return (alu_op == MUL_OP) || (alu_op == MAC_OP);
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// EX-side issue/result bundle between the pipeline and the MAC sequencer.
interface mac_sequencer_if #(
    parameter int DATA_W = 64
);
    logic              start;
    logic              mac_select;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              acc_clr;
    logic              flush;
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              busy;

    modport master (
        output start, mac_select, op_a, op_b, acc_clr, flush,
        input  stall, done, result, busy
    );

    modport slave (
        input  start, mac_select, op_a, op_b, acc_clr, flush,
        output stall, done, result, busy
    );

endinterface

// File: rtl/mac_iter_dp.sv
// Shift-add multiply datapath: operand shifters, partial product, acc adder.
module mac_iter_dp #(
    parameter int DATA_W = 64,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              load,
    input  logic              step,
    input  logic              mac,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] acc_base,
    output logic [DATA_W-1:0] res_nxt
);

    logic [DATA_W-1:0] a_sh;
    logic [DATA_W-1:0] b_sh;
    logic [DATA_W-1:0] pp;
    logic [DATA_W-1:0] partial;
    logic [DATA_W-1:0] pp_nxt;

    // Only the low DATA_W bits are kept, so the product is sign-agnostic.
    assign partial = a_sh * DATA_W'(b_sh[STEP_W-1:0]);
    assign pp_nxt  = pp + partial;
    assign res_nxt = mac ? (acc_base + pp_nxt) : pp_nxt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            pp   <= '0;
        end else if (load) begin
            a_sh <= op_a;
            b_sh <= op_b;
            pp   <= '0;
        end else if (step) begin
            a_sh <= a_sh << STEP_W;
            b_sh <= b_sh >> STEP_W;
            pp   <= pp_nxt;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Multi-cycle MUL/MAC sequencer for EX; owns the architectural accumulator.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int MUL_CYCLES = 4
) (
    input  logic           clk,
    input  logic           arst_n,
    mac_sequencer_if.slave bus
);

    localparam int STEP_W = DATA_W / MUL_CYCLES;
    localparam int CNT_W  = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

    mac_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic              mac_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] result_q;
    logic              done_q;
    logic              busy_q;
    logic              issue;
    logic              step;
    logic [DATA_W-1:0] acc_base;
    logic [DATA_W-1:0] res_nxt;

    assign issue = (state == IDLE) && bus.start && !bus.flush;
    assign step  = (state == BUSY) && !bus.flush;

    // A clear in the final BUSY cycle must also zero the sum seen in DONE.
    assign acc_base = bus.acc_clr ? '0 : acc;

    assign bus.stall  = issue || (state == BUSY);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;

    mac_iter_dp #(
        .DATA_W (DATA_W),
        .STEP_W (STEP_W)
    ) u_dp (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (issue),
        .step     (step),
        .mac      (mac_q),
        .op_a     (bus.op_a),
        .op_b     (bus.op_b),
        .acc_base (acc_base),
        .res_nxt  (res_nxt)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mac_q    <= 1'b0;
            acc      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.acc_clr) acc <= '0;
                    if (issue) begin
                        state  <= BUSY;
                        cnt    <= '0;
                        mac_q  <= bus.mac_select;
                        busy_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.acc_clr) acc <= '0;
                    if (bus.flush) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= res_nxt;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.acc_clr)  acc <= '0;
                    else if (mac_q)   acc <= result_q;
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: random and directed MUL/MAC traffic.
module tb_mac_sequencer;

    localparam int DW = 64;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic arst_n = 1'b0;

    always #5 clk = ~clk;

    mac_sequencer_if #(.DATA_W(DW)) bus ();

    mac_sequencer #(
        .DATA_W     (DW),
        .MUL_CYCLES (NC)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] acc_m;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (arst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got result %h expected no done",
                         bus.result);
            end else begin
                chk("result", bus.result, exp_q.pop_front());
            end
        end
    end

    // Issues one op starting at posedge+1; flush_at 1..4 = BUSY cycle, 5 = DONE.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input bit mac, input bit clr, input int flush_at,
                          input bit clr_done);
        logic [DW-1:0] expv;
        if (clr) acc_m = '0;
        expv = mac ? acc_m + a * b : a * b;
        if (flush_at < 1 || flush_at >= NC + 1) begin
            exp_q.push_back(expv);
            if (mac) acc_m = expv;
            if (clr_done) acc_m = '0;
        end
        bus.start      = 1'b1;
        bus.mac_select = mac;
        bus.op_a       = a;
        bus.op_b       = b;
        bus.acc_clr    = clr;
        @(negedge clk);
        chk("stall_c0", 64'(bus.stall), 64'd1);
        chk("busy_c0", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.acc_clr = 1'b0;
        bus.op_a    = {$urandom, $urandom};
        bus.op_b    = {$urandom, $urandom};
        for (int c = 1; c <= NC; c++) begin
            if (flush_at == c) bus.flush = 1'b1;
            @(negedge clk);
            chk($sformatf("stall_c%0d", c), 64'(bus.stall), 64'd1);
            chk($sformatf("busy_c%0d", c), 64'(bus.busy), 64'd1);
            @(posedge clk);
            #1;
            bus.flush = 1'b0;
            if (flush_at == c) begin
                @(negedge clk);
                chk("stall_after_flush", 64'(bus.stall), 64'd0);
                chk("busy_after_flush", 64'(bus.busy), 64'd0);
                @(posedge clk);
                #1;
                return;
            end
        end
        if (flush_at == NC + 1) bus.flush = 1'b1;
        if (clr_done) bus.acc_clr = 1'b1;
        @(negedge clk);
        chk("done_pulse", 64'(bus.done), 64'd1);
        chk("stall_done", 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        bus.flush   = 1'b0;
        bus.acc_clr = 1'b0;
        chk("done_low_after", 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] ones;
        bus.start      = 1'b0;
        bus.mac_select = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.acc_clr    = 1'b0;
        bus.flush      = 1'b0;
        acc_m          = '0;
        ones           = '1;

        #12;
        chk("rst_result", bus.result, 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic MUL, then read the accumulator back with a MAC of zeros.
        run_op(64'd3, 64'd5, 1'b0, 1'b0, -1, 1'b0);
        run_op(64'd0, 64'd0, 1'b1, 1'b0, -1, 1'b0);

        // Back-to-back MAC chain.
        run_op(64'd2, 64'd7, 1'b1, 1'b0, -1, 1'b0);
        run_op(64'd4, 64'd4, 1'b1, 1'b0, -1, 1'b0);

        // Wrap-around, MUL and MAC onto acc=3.
        run_op(ones, 64'd2, 1'b0, 1'b0, -1, 1'b0);
        run_op(64'd1, 64'd3, 1'b1, 1'b1, -1, 1'b0);
        run_op(ones, 64'd2, 1'b1, 1'b0, -1, 1'b0);

        // Flush in BUSY, then in DONE, with acc=10.
        run_op(64'd2, 64'd5, 1'b1, 1'b1, -1, 1'b0);
        run_op(64'd9, 64'd9, 1'b1, 1'b0, 2, 1'b0);
        run_op(64'd0, 64'd0, 1'b1, 1'b0, -1, 1'b0);
        run_op(64'd9, 64'd9, 1'b1, 1'b0, NC + 1, 1'b0);
        run_op(64'd0, 64'd0, 1'b1, 1'b0, -1, 1'b0);

        // Accumulator clear with start, and during DONE.
        run_op(64'd5, 64'd10, 1'b1, 1'b1, -1, 1'b0);
        run_op(64'd6, 64'd6, 1'b1, 1'b1, -1, 1'b0);
        run_op(64'd1, 64'd1, 1'b1, 1'b0, -1, 1'b1);
        run_op(64'd0, 64'd0, 1'b1, 1'b0, -1, 1'b0);

        // Async reset mid-BUSY, off the clock edge.
        run_op(64'd7, 64'd3, 1'b1, 1'b0, -1, 1'b0);
        bus.start      = 1'b1;
        bus.mac_select = 1'b1;
        bus.op_a       = 64'd11;
        bus.op_b       = 64'd13;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_result", bus.result, 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_stall", 64'(bus.stall), 64'd0);
        acc_m = '0;
        #11;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(64'd8, 64'd8, 1'b0, 1'b0, -1, 1'b0);
        run_op(64'd0, 64'd0, 1'b1, 1'b0, -1, 1'b0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            int fa;
            a  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 255))
                                              : {$urandom, $urandom};
            b  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 255))
                                              : {$urandom, $urandom};
            fa = ($urandom_range(0, 5) == 0) ? $urandom_range(1, NC + 1) : -1;
            run_op(a, b, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0), fa,
                   ($urandom_range(0, 7) == 0));
        end
        run_op(64'd0, 64'd0, 1'b1, 1'b0, -1, 1'b0);

        repeat (3) @(posedge clk);
        chk("pending_results", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
